// File: rtl/spi_pkg.sv
// Shared types and helpers for the spi_master_mc SPI master and its clock generator.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  // Mode encoding is {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Counter width that stays at least one bit for n <= 2.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK divider: registered sclk plus single-cycle lead/trail strobes that
// mark the clk edge on which sclk leaves or returns to its idle level.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpol,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int CW = clog2w(CLKDIV);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          tick;

  assign tick  = en && (cnt_q == LAST);
  assign lead  = tick && (sclk_q == cpol);
  assign trail = tick && (sclk_q != cpol);
  assign sclk  = sclk_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      sclk_q <= cpol;
    end else if (tick) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised full-duplex SPI master with decoded slave selects and all four modes.
// Optional feature: define SPI_LOOPBACK_EN to add the internal loopback input.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NCS    = 1,
  parameter int CLKDIV = 2,
  parameter int SELW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [SELW-1:0]   sel,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              done,
  output logic              rx_valid,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NCS-1:0]    ss_n
);

  localparam int BCW = $clog2(2 * DWIDTH);
  localparam int PCW = clog2w(CLKDIV);
  localparam logic [BCW-1:0] LAST_EDGE = BCW'(2 * DWIDTH - 1);
  localparam logic [PCW-1:0] LAST_PH   = PCW'(CLKDIV - 1);
  localparam logic [31:0]    NCS_U     = 32'(NCS);

  spi_state_t        state_q, state_d;
  logic [DWIDTH-1:0] shreg_q, dout_q;
  logic [1:0]        mode_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic [PCW-1:0]    ph_cnt_q;
  logic [NCS-1:0]    ss_n_q, ss_n_d;
  logic              mosi_q, rx_bit_q, rx_valid_q, err_q;
  logic              wr_ev, rd_ev, sel_ok, accept, finish, ph_last;
  logic              lead, trail, cpol, cpha, rx_in, err_set;

  assign wr_ev   = cs & wr;
  assign rd_ev   = cs & rd;
  assign done    = (state_q == IDLE);
  assign sel_ok  = (32'(sel) < NCS_U);
  assign accept  = wr_ev & done & sel_ok;
  assign cpha    = (mode_q == SPI_MODE1) || (mode_q == SPI_MODE3);
  assign cpol    = (mode_q == SPI_MODE2) || (mode_q == SPI_MODE3);
  assign ph_last = (ph_cnt_q == LAST_PH);
  // A read in the completion cycle consumes the old word, so it is not an overrun.
  assign err_set = (wr_ev & ~accept) | (finish & rx_valid_q & ~rd_ev);

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lb_q <= 1'b0;
    else if (accept) lb_q <= loopback;
  end
  assign rx_in  = lb_q ? mosi_q : miso;
  assign ss_n_d = loopback ? '1 : ~(NCS'(1) << sel);
`else
  assign rx_in  = miso;
  assign ss_n_d = ~(NCS'(1) << sel);
`endif

  // The new CPOL is forwarded on accept so sclk sits at it from the first SETUP cycle.
  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == XFER),
    .cpol  (accept ? mode[1] : cpol),
    .lead  (lead),
    .trail (trail),
    .sclk  (sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (ph_last) state_d = XFER;
      XFER:  if ((lead | trail) && bit_cnt_q == LAST_EDGE) state_d = HOLD;
      HOLD: begin
        if (ph_last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      dout_q     <= '0;
      mode_q     <= SPI_MODE0;
      bit_cnt_q  <= '0;
      ph_cnt_q   <= '0;
      ss_n_q     <= '1;
      mosi_q     <= 1'b0;
      rx_bit_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_d != state_q)                   ph_cnt_q <= '0;
      else if (state_q == SETUP || state_q == HOLD) ph_cnt_q <= ph_cnt_q + 1'b1;

      if (accept) begin
        shreg_q   <= din;
        mode_q    <= mode;
        bit_cnt_q <= '0;
        ss_n_q    <= ss_n_d;
        if (mode == SPI_MODE0 || mode == SPI_MODE2) mosi_q <= din[DWIDTH-1];
      end

      if (lead | trail) bit_cnt_q <= bit_cnt_q + 1'b1;

      if (lead) begin
        if (!cpha) rx_bit_q <= rx_in;
        else       mosi_q   <= shreg_q[DWIDTH-1];
      end

      if (trail) begin
        if (!cpha) begin
          shreg_q <= {shreg_q[DWIDTH-2:0], rx_bit_q};
          mosi_q  <= shreg_q[DWIDTH-2];
        end else begin
          shreg_q <= {shreg_q[DWIDTH-2:0], rx_in};
        end
      end

      if (finish) begin
        ss_n_q <= '1;
        dout_q <= shreg_q;
      end

      if (finish)     rx_valid_q <= 1'b1;
      else if (rd_ev) rx_valid_q <= 1'b0;

      if (err_set)    err_q <= 1'b1;
      else if (rd_ev) err_q <= 1'b0;
    end
  end

  assign dout     = dout_q;
  assign rx_valid = rx_valid_q;
  assign err      = err_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc: behavioural SPI slave plus a flag/timing
// model, directed corner cases followed by randomised transfers.
module tb_spi_master_mc;
  import spi_pkg::*;

  localparam int DW     = 8;
  localparam int NCS    = 3;
  localparam int CLKDIV = 2;
  localparam int SELW   = 2;
  localparam int T      = (2 * DW + 2) * CLKDIV;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cs = 1'b0, wr = 1'b0, rd = 1'b0, miso = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [1:0]      mode = '0;
  logic [DW-1:0]   din = '0;
  logic [DW-1:0]   dout;
  logic            done, rx_valid, err, sclk, mosi;
  logic [NCS-1:0]  ss_n;
`ifdef SPI_LOOPBACK_EN
  logic            loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_master_mc #(.DWIDTH(DW), .NCS(NCS), .CLKDIV(CLKDIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .wr       (wr),
    .rd       (rd),
    .sel      (sel),
    .mode     (mode),
    .din      (din),
    .dout     (dout),
    .done     (done),
    .rx_valid (rx_valid),
    .err      (err),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
`ifdef SPI_LOOPBACK_EN
    .loopback (loopback),
`endif
    .ss_n     (ss_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: bit-indexed, reacts to sclk levels relative to CPOL.
  logic [DW-1:0] slv_tx = '0, slv_rx = '0;
  int            slv_sel = 0;
  logic          slv_cpol = 1'b0, slv_cpha = 1'b0;
  int            lead_n = 0, trail_n = 0;
  logic          slv_on = 1'b0, slv_on_q = 1'b0, sclk_seen = 1'b0;

  always @(sclk or ss_n) begin
    slv_on = !ss_n[slv_sel];
    if (slv_on && !slv_on_q) begin
      lead_n  = 0;
      trail_n = 0;
      slv_rx  = '0;
      if (!slv_cpha) miso = slv_tx[DW-1];
    end else if (slv_on && sclk !== sclk_seen) begin
      if (sclk !== slv_cpol) begin
        if (slv_cpha) begin
          if (lead_n < DW) miso = slv_tx[DW-1-lead_n];
        end else begin
          slv_rx = {slv_rx[DW-2:0], mosi};
        end
        lead_n++;
      end else begin
        if (slv_cpha) slv_rx = {slv_rx[DW-2:0], mosi};
        trail_n++;
        if (!slv_cpha && trail_n < DW) miso = slv_tx[DW-1-trail_n];
      end
    end
    slv_on_q  = slv_on;
    sclk_seen = sclk;
  end

  logic          exp_rx  = 1'b0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] exp_dout = '0;

  task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] stx, input int s,
                      input logic [1:0] m, input bit no_wait, input bit busy_wr,
                      input bit rd_end);
    int n, toggles, run, bad_run, ss_cnt, other;
    logic prev;
    logic [NCS-1:0] others;
    if (!no_wait) @(negedge clk);
    slv_sel = s; slv_cpol = m[1]; slv_cpha = m[0]; slv_tx = stx;
    cs = 1'b1; wr = 1'b1; din = tx; sel = SELW'(s); mode = m;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    check("sclk_setup", sclk, m[1]);
    n = 0; toggles = 0; run = 0; bad_run = 0; ss_cnt = 0; other = 0; prev = sclk;
    while (!done && n < 4 * T) begin
      if (!ss_n[s]) ss_cnt++;
      others = ss_n | (NCS'(1) << s);
      if (others != {NCS{1'b1}}) other++;
      if (sclk !== prev) begin
        if (toggles > 0 && run != CLKDIV) bad_run++;
        toggles++;
        run = 1;
      end else begin
        run++;
      end
      prev = sclk;
      cs = 1'b0; wr = 1'b0; rd = 1'b0;
      if (busy_wr && n == 5) begin
        cs = 1'b1; wr = 1'b1; din = 8'h0F;
      end else if (rd_end && n == T - 1) begin
        cs = 1'b1; rd = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    if (busy_wr) exp_err = 1'b1;
    if (rd_end) begin
      exp_err = 1'b0;
    end else if (exp_rx) begin
      exp_err = 1'b1;
    end
    exp_rx   = 1'b1;
    exp_dout = stx;
    check("done_low_cycles", n, T);
    check("ss_low_cycles", ss_cnt, T);
    check("other_ss_low", other, 0);
    check("sclk_edges", toggles, 2 * DW);
    check("sclk_half_period", bad_run, 0);
    check("sclk_idle", sclk, m[1]);
    check("ss_idle", ss_n, {NCS{1'b1}});
    check("dout", dout, exp_dout);
    check("rx_valid", rx_valid, exp_rx);
    check("err", err, exp_err);
    check("slave_rx", slv_rx, tx);
    check("slave_lead_edges", lead_n, DW);
    check("slave_trail_edges", trail_n, DW);
  endtask

  task automatic host_rd();
    @(negedge clk);
    cs = 1'b1; rd = 1'b1;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    exp_rx  = 1'b0;
    exp_err = 1'b0;
    check("rd_rx_valid", rx_valid, 1'b0);
    check("rd_err", err, 1'b0);
    check("rd_dout_kept", dout, exp_dout);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sclk"}, sclk, 1'b0);
    check({tag, "_mosi"}, mosi, 1'b0);
    check({tag, "_ss_n"}, ss_n, {NCS{1'b1}});
    check({tag, "_dout"}, dout, '0);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a, b;
    int s;
    logic [1:0] m;
    bit do_rd, b2b, bw, re;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Mode 0 reference transfer: 36 busy cycles.
    xfer(8'hAA, 8'h5A, 0, SPI_MODE0, 1'b0, 1'b0, 1'b0);

    // All four modes return the slave word.
    for (int i = 0; i < 4; i++) begin
      host_rd();
      xfer(8'hA5, 8'h34, 1, 2'(i), 1'b0, 1'b0, 1'b0);
    end

    // Every valid select, then an out-of-range select.
    for (int i = 0; i < NCS; i++) begin
      host_rd();
      xfer(8'h3C ^ 8'(i), 8'hC0 | 8'(i), i, SPI_MODE1, 1'b0, 1'b0, 1'b0);
    end
    host_rd();
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; sel = 2'd3; din = 8'h77;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    exp_err = 1'b1;
    check("badsel_err", err, 1'b1);
    check("badsel_done", done, 1'b1);
    check("badsel_ss", ss_n, {NCS{1'b1}});
    repeat (3) @(negedge clk);
    check("badsel_still_idle", done, 1'b1);
    check("badsel_rx_valid", rx_valid, 1'b0);
    host_rd();

    // Write while busy is ignored and flagged.
    xfer(8'h96, 8'h69, 2, SPI_MODE2, 1'b0, 1'b1, 1'b0);
    host_rd();

    // Overrun via back-to-back transfers, then a read in the completion cycle.
    xfer(8'h11, 8'h22, 0, SPI_MODE3, 1'b0, 1'b0, 1'b0);
    xfer(8'h33, 8'h44, 1, SPI_MODE0, 1'b1, 1'b0, 1'b0);
    xfer(8'h55, 8'h66, 2, SPI_MODE1, 1'b1, 1'b0, 1'b1);

    // Reset mid-transfer aborts asynchronously.
    @(negedge clk);
    slv_sel = 1; slv_cpol = 1'b1; slv_cpha = 1'b0; slv_tx = 8'hE7;
    cs = 1'b1; wr = 1'b1; sel = 2'd1; mode = SPI_MODE2; din = 8'hF0;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    repeat (9) @(negedge clk);
    check("midxfer_busy", done, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    exp_rx = 1'b0; exp_err = 1'b0; exp_dout = '0;
    xfer(8'h81, 8'h7E, 0, SPI_MODE3, 1'b0, 1'b0, 1'b0);

    // Randomised transfers.
    for (int i = 0; i < 20; i++) begin
      a     = DW'($urandom);
      b     = DW'($urandom);
      s     = int'($urandom_range(NCS - 1));
      m     = 2'($urandom_range(3));
      do_rd = ($urandom_range(1) == 1);
      b2b   = !do_rd && ($urandom_range(1) == 1);
      bw    = ($urandom_range(3) == 0);
      re    = ($urandom_range(3) == 0);
      if (do_rd) host_rd();
      xfer(a, b, s, m, b2b, bw, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
